// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer for the pipelined core.
// Owns the PC, resolves BEQ/JUMP redirects coming from MEM, keeps N_LOOPS
// loop-limit counters and either wraps or halts at the end of the program.
module pc_sequencer #(
    parameter int                 ADDR_W   = 8,
    parameter int                 CNT_W    = 8,
    parameter int                 N_LOOPS  = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC = {ADDR_W{1'b0}},
    parameter logic [ADDR_W-1:0]  END_ADDR = {ADDR_W{1'b1}},
    localparam int                LID_W    = $clog2(N_LOOPS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              branch_req,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              jump_req,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic [LID_W-1:0]  jump_id,
    input  logic [CNT_W-1:0]  jump_limit,
    input  logic              loop_clr,
    input  logic              wrap_en,
    input  logic              resume,
    input  logic [LID_W-1:0]  cnt_sel,
    output logic [ADDR_W-1:0] pc,
    output logic              flush,
    output logic              jump_taken,
    output logic              halted,
    output logic [CNT_W-1:0]  cnt_rd
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0]   cnt_q [N_LOOPS];
    logic [CNT_W-1:0]   cnt_d [N_LOOPS];

    logic               flush_s;
    logic               jump_taken_s;
    logic               jid_valid_s;
    logic [CNT_W-1:0]   jcnt_s;
    logic               jump_ok_s;

    // Counter addressed by the JUMP in MEM; an out-of-range id reads as zero.
    always_comb begin
        jid_valid_s = (int'(jump_id) < N_LOOPS);
        if (jid_valid_s) begin
            jcnt_s = cnt_q[jump_id];
        end else begin
            jcnt_s = CNT_ZERO;
        end
        jump_ok_s = (jump_limit == CNT_ZERO) || (jcnt_s < jump_limit);
    end

    // Next-state, next-PC and counter update; redirects beat end-of-program and stall.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        cnt_d        = cnt_q;
        flush_s      = 1'b0;
        jump_taken_s = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (branch_req) begin
                    pc_d    = branch_target;
                    flush_s = 1'b1;
                end else if (jump_req && jump_ok_s) begin
                    pc_d         = jump_target;
                    flush_s      = 1'b1;
                    jump_taken_s = 1'b1;
                    if (jid_valid_s) begin
                        if (jcnt_s == CNT_MAX) begin
                            cnt_d[jump_id] = CNT_MAX;
                        end else begin
                            cnt_d[jump_id] = jcnt_s + CNT_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q;
                    end
                end else begin
                    // A JUMP that exhausted its limit falls through and re-arms its loop.
                    if (jump_req && jid_valid_s) begin
                        cnt_d[jump_id] = CNT_ZERO;
                    end else begin
                        cnt_d = cnt_q;
                    end
                    if (pc_q == END_ADDR) begin
                        if (wrap_en) begin
                            pc_d = RESET_PC;
                        end else begin
                            pc_d    = pc_q;
                            state_d = ST_HALT;
                        end
                    end else if (stall) begin
                        pc_d = pc_q;
                    end else begin
                        pc_d = pc_q + ADDR_W'(1);
                    end
                end
            end
            ST_HALT: begin
                if (resume) begin
                    pc_d    = RESET_PC;
                    state_d = ST_RUN;
                end else begin
                    pc_d    = pc_q;
                    state_d = ST_HALT;
                end
            end
            default: begin
                pc_d    = RESET_PC;
                state_d = ST_RUN;
            end
        endcase

        // Clearing all loops wins over any same-cycle increment or re-arm.
        if (loop_clr) begin
            for (int i = 0; i < N_LOOPS; i++) begin
                cnt_d[i] = CNT_ZERO;
            end
        end else begin
            cnt_d = cnt_d;
        end
    end

    // State, PC and loop-counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            for (int i = 0; i < N_LOOPS; i++) begin
                cnt_q[i] <= CNT_ZERO;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            for (int i = 0; i < N_LOOPS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Counter read port shows the pre-edge value; out-of-range select reads zero.
    always_comb begin
        if (int'(cnt_sel) < N_LOOPS) begin
            cnt_rd = cnt_q[cnt_sel];
        end else begin
            cnt_rd = CNT_ZERO;
        end
    end

    assign pc         = pc_q;
    assign halted     = (state_q == ST_HALT);
    assign flush      = flush_s & ~rst;
    assign jump_taken = jump_taken_s & ~rst;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: table-driven directed test of pc_sequencer plus hand-written
// sequences for counter saturation.
module tb_pc_sequencer;

    localparam int NV = 40;

    logic       clk = 1'b0;
    logic       rst, stall, branch_req, jump_req, loop_clr, wrap_en, resume;
    logic [7:0] branch_target, jump_target, jump_limit;
    logic [1:0] jump_id, cnt_sel;
    logic [7:0] pc, cnt_rd;
    logic       flush, jump_taken, halted;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       rst, stall, br;
        logic [7:0] bt;
        logic       jr;
        logic [7:0] jt;
        logic [1:0] jid;
        logic [7:0] jlim;
        logic       clr, wrap, res;
        logic [1:0] sel;
        logic [7:0] e_pc;
        logic       e_fl, e_jt, e_h;
        logic [7:0] e_cnt;
    } vec_t;

    vec_t tbl [NV];

    pc_sequencer dut (
        .clk(clk), .rst(rst), .stall(stall),
        .branch_req(branch_req), .branch_target(branch_target),
        .jump_req(jump_req), .jump_target(jump_target), .jump_id(jump_id),
        .jump_limit(jump_limit), .loop_clr(loop_clr), .wrap_en(wrap_en),
        .resume(resume), .cnt_sel(cnt_sel),
        .pc(pc), .flush(flush), .jump_taken(jump_taken), .halted(halted),
        .cnt_rd(cnt_rd)
    );

    always #5 clk = ~clk;

    function automatic vec_t v(
        input logic r, s, br, input logic [7:0] bt,
        input logic jr, input logic [7:0] jt, input logic [1:0] jid, input logic [7:0] jlim,
        input logic clr, wrap, res, input logic [1:0] sel,
        input logic [7:0] epc, input logic efl, ejt, eh, input logic [7:0] ecnt);
        vec_t t;
        t.rst = r; t.stall = s; t.br = br; t.bt = bt;
        t.jr = jr; t.jt = jt; t.jid = jid; t.jlim = jlim;
        t.clr = clr; t.wrap = wrap; t.res = res; t.sel = sel;
        t.e_pc = epc; t.e_fl = efl; t.e_jt = ejt; t.e_h = eh; t.e_cnt = ecnt;
        return t;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s vec=%0d actual=0x%0h expected=0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        rst = t.rst; stall = t.stall; branch_req = t.br; branch_target = t.bt;
        jump_req = t.jr; jump_target = t.jt; jump_id = t.jid; jump_limit = t.jlim;
        loop_clr = t.clr; wrap_en = t.wrap; resume = t.res; cnt_sel = t.sel;
    endtask

    initial begin
        //          rst s br bt     jr jt     jid  jlim  clr wr rs sel   pc     fl jt h  cnt
        tbl[0]  = v(1, 0, 1, 8'h40, 0, 8'h00, 2'd0, 8'd0, 0, 1, 0, 2'd0, 8'h00, 0, 0, 0, 8'd0);
        tbl[1]  = v(0, 0, 0, 8'h00, 0, 8'h00, 2'd0, 8'd0, 0, 1, 0, 2'd0, 8'h00, 0, 0, 0, 8'd0);
        tbl[2]  = v(0, 0, 0, 8'h00, 0, 8'h00, 2'd0, 8'd0, 0, 1, 0, 2'd0, 8'h01, 0, 0, 0, 8'd0);
        tbl[3]  = v(0, 0, 0, 8'h00, 0, 8'h00, 2'd0, 8'd0, 0, 1, 0, 2'd0, 8'h02, 0, 0, 0, 8'd0);
        tbl[4]  = v(0, 0, 0, 8'h00, 0, 8'h00, 2'd0, 8'd0, 0, 1, 0, 2'd0, 8'h03, 0, 0, 0, 8'd0);
        tbl[5]  = v(0, 0, 0, 8'h00, 0, 8'h00, 2'd0, 8'd0, 0, 1, 0, 2'd0, 8'h04, 0, 0, 0, 8'd0);
        tbl[6]  = v(0, 1, 0, 8'h00, 0, 8'h00, 2'd0, 8'd0, 0, 1, 0, 2'd0, 8'h05, 0, 0, 0, 8'd0);
        tbl[7]  = v(0, 1, 0, 8'h00, 0, 8'h00, 2'd0, 8'd0, 0, 1, 0, 2'd0, 8'h05, 0, 0, 0, 8'd0);
        tbl[8]  = v(0, 0, 0, 8'h00, 0, 8'h00, 2'd0, 8'd0, 0, 1, 0, 2'd0, 8'h05, 0, 0, 0, 8'd0);
        // JUMP id1 limit 3: three taken, fourth falls through and re-arms
        tbl[9]  = v(0, 0, 0, 8'h00, 1, 8'h10, 2'd1, 8'd3, 0, 1, 0, 2'd1, 8'h06, 1, 1, 0, 8'd0);
        tbl[10] = v(0, 0, 0, 8'h00, 1, 8'h10, 2'd1, 8'd3, 0, 1, 0, 2'd1, 8'h10, 1, 1, 0, 8'd1);
        tbl[11] = v(0, 0, 0, 8'h00, 1, 8'h10, 2'd1, 8'd3, 0, 1, 0, 2'd1, 8'h10, 1, 1, 0, 8'd2);
        tbl[12] = v(0, 0, 0, 8'h00, 1, 8'h10, 2'd1, 8'd3, 0, 1, 0, 2'd1, 8'h10, 0, 0, 0, 8'd3);
        tbl[13] = v(0, 0, 0, 8'h00, 0, 8'h00, 2'd0, 8'd0, 0, 1, 0, 2'd1, 8'h11, 0, 0, 0, 8'd0);
        // branch beats jump in the same cycle
        tbl[14] = v(0, 0, 1, 8'h20, 1, 8'h30, 2'd1, 8'd0, 0, 1, 0, 2'd1, 8'h12, 1, 0, 0, 8'd0);
        tbl[15] = v(0, 0, 0, 8'h00, 0, 8'h00, 2'd0, 8'd0, 0, 1, 0, 2'd1, 8'h20, 0, 0, 0, 8'd0);
        // branch overrides stall
        tbl[16] = v(0, 1, 1, 8'h80, 0, 8'h00, 2'd0, 8'd0, 0, 1, 0, 2'd0, 8'h21, 1, 0, 0, 8'd0);
        tbl[17] = v(0, 0, 0, 8'h00, 0, 8'h00, 2'd0, 8'd0, 0, 1, 0, 2'd0, 8'h80, 0, 0, 0, 8'd0);
        // halt at END_ADDR, HALT ignores redirects, resume
        tbl[18] = v(0, 0, 1, 8'hFF, 0, 8'h00, 2'd0, 8'd0, 0, 0, 0, 2'd0, 8'h81, 1, 0, 0, 8'd0);
        tbl[19] = v(0, 0, 0, 8'h00, 0, 8'h00, 2'd0, 8'd0, 0, 0, 0, 2'd0, 8'hFF, 0, 0, 0, 8'd0);
        tbl[20] = v(0, 1, 1, 8'h40, 1, 8'h44, 2'd0, 8'd0, 0, 0, 0, 2'd0, 8'hFF, 0, 0, 1, 8'd0);
        tbl[21] = v(0, 0, 0, 8'h00, 0, 8'h00, 2'd0, 8'd0, 0, 0, 1, 2'd0, 8'hFF, 0, 0, 1, 8'd0);
        tbl[22] = v(0, 0, 0, 8'h00, 0, 8'h00, 2'd0, 8'd0, 0, 0, 0, 2'd0, 8'h00, 0, 0, 0, 8'd0);
        // wrap at END_ADDR
        tbl[23] = v(0, 0, 1, 8'hFF, 0, 8'h00, 2'd0, 8'd0, 0, 1, 0, 2'd0, 8'h01, 1, 0, 0, 8'd0);
        tbl[24] = v(0, 0, 0, 8'h00, 0, 8'h00, 2'd0, 8'd0, 0, 1, 0, 2'd0, 8'hFF, 0, 0, 0, 8'd0);
        tbl[25] = v(0, 0, 0, 8'h00, 0, 8'h00, 2'd0, 8'd0, 0, 1, 0, 2'd0, 8'h00, 0, 0, 0, 8'd0);
        // jump at END_ADDR with wrap off redirects, no halt
        tbl[26] = v(0, 0, 1, 8'hFF, 0, 8'h00, 2'd0, 8'd0, 0, 1, 0, 2'd0, 8'h01, 1, 0, 0, 8'd0);
        tbl[27] = v(0, 0, 0, 8'h00, 1, 8'h05, 2'd0, 8'd0, 0, 0, 0, 2'd0, 8'hFF, 1, 1, 0, 8'd0);
        tbl[28] = v(0, 0, 0, 8'h00, 0, 8'h00, 2'd0, 8'd0, 0, 0, 0, 2'd0, 8'h05, 0, 0, 0, 8'd1);
        // loop_clr beats a same-cycle increment
        tbl[29] = v(0, 0, 0, 8'h00, 1, 8'h08, 2'd0, 8'd0, 1, 1, 0, 2'd0, 8'h06, 1, 1, 0, 8'd1);
        tbl[30] = v(0, 0, 0, 8'h00, 0, 8'h00, 2'd0, 8'd0, 0, 1, 0, 2'd0, 8'h08, 0, 0, 0, 8'd0);
        // reset mid-loop with count[2]=2, loop_clr and jump also asserted
        tbl[31] = v(0, 0, 0, 8'h00, 1, 8'h30, 2'd2, 8'd5, 0, 1, 0, 2'd2, 8'h09, 1, 1, 0, 8'd0);
        tbl[32] = v(0, 0, 0, 8'h00, 1, 8'h30, 2'd2, 8'd5, 0, 1, 0, 2'd2, 8'h30, 1, 1, 0, 8'd1);
        tbl[33] = v(1, 0, 0, 8'h00, 1, 8'h30, 2'd2, 8'd5, 1, 1, 0, 2'd2, 8'h30, 0, 0, 0, 8'd2);
        tbl[34] = v(0, 0, 0, 8'h00, 0, 8'h00, 2'd0, 8'd0, 0, 1, 0, 2'd2, 8'h00, 0, 0, 0, 8'd0);
        tbl[35] = v(0, 0, 0, 8'h00, 0, 8'h00, 2'd0, 8'd0, 0, 1, 0, 2'd1, 8'h01, 0, 0, 0, 8'd0);
        // reset while halted
        tbl[36] = v(0, 0, 1, 8'hFF, 0, 8'h00, 2'd0, 8'd0, 0, 0, 0, 2'd0, 8'h02, 1, 0, 0, 8'd0);
        tbl[37] = v(0, 0, 0, 8'h00, 0, 8'h00, 2'd0, 8'd0, 0, 0, 0, 2'd0, 8'hFF, 0, 0, 0, 8'd0);
        tbl[38] = v(1, 0, 0, 8'h00, 0, 8'h00, 2'd0, 8'd0, 0, 0, 0, 2'd0, 8'hFF, 0, 0, 1, 8'd0);
        tbl[39] = v(0, 0, 0, 8'h00, 0, 8'h00, 2'd0, 8'd0, 0, 1, 0, 2'd0, 8'h00, 0, 0, 0, 8'd0);

        // Preamble: bring the design out of its unknown power-up state.
        drive(v(1, 0, 0, 8'h00, 0, 8'h00, 2'd0, 8'd0, 0, 1, 0, 2'd0, 8'h00, 0, 0, 0, 8'd0));
        repeat (2) @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(tbl[i]);
            #1;
            check("pc",         i, 32'(pc),         32'(tbl[i].e_pc));
            check("flush",      i, 32'(flush),      32'(tbl[i].e_fl));
            check("jump_taken", i, 32'(jump_taken), 32'(tbl[i].e_jt));
            check("halted",     i, 32'(halted),     32'(tbl[i].e_h));
            check("cnt_rd",     i, 32'(cnt_rd),     32'(tbl[i].e_cnt));
        end

        // Saturation: unlimited JUMP on counter 3, 260 times; count sticks at 255.
        for (int k = 0; k < 260; k++) begin
            @(negedge clk);
            drive(v(0, 0, 0, 8'h00, 1, 8'h50, 2'd3, 8'd0, 0, 1, 0, 2'd3, 8'h00, 0, 0, 0, 8'd0));
            #1;
            check("sat_cnt",  100 + k, 32'(cnt_rd),     (k > 255) ? 32'd255 : 32'(k));
            check("sat_jt",   100 + k, 32'(jump_taken), 32'd1);
        end
        // Limit 255 with count 255: not taken, re-arms to zero.
        @(negedge clk);
        drive(v(0, 0, 0, 8'h00, 1, 8'h60, 2'd3, 8'd255, 0, 1, 0, 2'd3, 8'h00, 0, 0, 0, 8'd0));
        #1;
        check("lim255_jt",  400, 32'(jump_taken), 32'd0);
        check("lim255_pc",  400, 32'(pc),         32'h50);
        @(negedge clk);
        drive(v(0, 0, 0, 8'h00, 0, 8'h00, 2'd0, 8'd0, 0, 1, 0, 2'd3, 8'h00, 0, 0, 0, 8'd0));
        #1;
        check("rearm_cnt",  401, 32'(cnt_rd), 32'd0);
        check("rearm_pc",   401, 32'(pc),     32'h51);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
